cordic_result_reader: RTL and testbench

- Consumer side of the CORDIC datapath stream: accepts the DATA_WIDTH-bit valid-only word stream (i_vld/i_data) produced by cordic_wrapper.
- Buffers words in a small FIFO and serialises each word MSB-first into SLICE_WIDTH-bit slices on a ready/valid downstream port (pad/scan-out or host capture).
- Flags the terminating word (low INPUT_DATA_WIDTH bits equal to i_stop_code), counts transferred words and reports dropped words.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_sync_fifo.sv | 74 +++++++
 rtl/cordic_result_reader.sv | 148 ++++++++++++++
 tb/tb_cordic_result_reader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath stream blocks: default widths,
// slice-count derivation and the result-reader state encoding.
package cordic_pkg;

    localparam int unsigned CORDIC_DATA_WIDTH       = 56;
    localparam int unsigned CORDIC_INPUT_DATA_WIDTH = 49;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } rdr_state_t;

    function automatic int unsigned num_slices(input int unsigned data_w,
                                               input int unsigned slice_w);
        return data_w / slice_w;
    endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush. A push into a
// full FIFO is accepted when a pop happens on the same edge.
module cordic_sync_fifo #(
    parameter int unsigned WIDTH = 56,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_result_reader.sv
// Buffers CORDIC result words and serialises them MSB-first into slices on a
// ready/valid port, flagging the terminator word and counting transfers.
module cordic_result_reader
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = CORDIC_DATA_WIDTH,
    parameter int unsigned INPUT_DATA_WIDTH = CORDIC_INPUT_DATA_WIDTH,
    parameter int unsigned SLICE_WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        i_clk,
    input  logic                        i_async_rst,
    input  logic                        i_enable,
    input  logic [INPUT_DATA_WIDTH-1:0] i_stop_code,
    input  logic                        i_vld,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_rdy,
    output logic                        o_vld,
    output logic [SLICE_WIDTH-1:0]      o_slice,
    output logic                        o_last,
    output logic [CNT_WIDTH-1:0]        o_word_cnt,
    output logic                        o_overflow,
    output logic                        o_busy
);

    localparam int unsigned NUM_SLICES = num_slices(DATA_WIDTH, SLICE_WIDTH);
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int unsigned FCW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    rdr_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  match_q, match_d;
    logic                  vld_q, vld_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [FCW-1:0]        fifo_count;
    logic                  load;

    cordic_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_async_rst),
        .flush_i (fifo_flush),
        .push_i  (i_vld && i_enable),
        .wdata_i (i_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        match_d    = match_q;
        vld_d      = vld_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            SEND: begin
                if (vld_q && i_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (match_q) begin
                            state_d = DONE;
                            vld_d   = 1'b0;
                        end else if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            vld_d   = 1'b0;
                        end
                    end else begin
                        shift_d = shift_q << SLICE_WIDTH;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (!i_enable) begin
                    fifo_flush = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase

        // Loading pops the head so the next word follows the last slice with no bubble.
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            match_d  = (fifo_head[INPUT_DATA_WIDTH-1:0] == i_stop_code);
            idx_d    = '0;
            vld_d    = 1'b1;
            state_d  = SEND;
        end

        ovf_d = ovf_q | (i_vld && i_enable && fifo_full && !fifo_pop);
    end

    always_ff @(posedge i_clk or negedge i_async_rst) begin
        if (!i_async_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            match_q <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_vld      = vld_q;
    assign o_slice    = shift_q[DATA_WIDTH-1 -: SLICE_WIDTH];
    assign o_last     = vld_q && match_q && (idx_q == LAST_IDX);
    assign o_word_cnt = cnt_q;
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_cordic_result_reader.sv
// Randomised and directed bench for cordic_result_reader against a queue-based
// transaction model of the word stream.
module tb_cordic_result_reader;

    logic        i_clk = 1'b0;
    logic        i_async_rst = 1'b0;
    logic        i_enable = 1'b0;
    logic [48:0] i_stop_code = 49'h0_DEAD_BEEF_0000;
    logic        i_vld = 1'b0;
    logic [55:0] i_data = '0;
    logic        i_rdy = 1'b0;
    logic        o_vld;
    logic [7:0]  o_slice;
    logic        o_last;
    logic [15:0] o_word_cnt;
    logic        o_overflow;
    logic        o_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: buffered words, word being sent, slices still to send.
    logic [55:0] m_fifo[$];
    logic [55:0] m_cur;
    int          m_rem;
    logic        m_match;
    logic        m_done;
    logic [15:0] m_cnt;
    logic        m_ovf;

    wire [27:0] obs_w = {o_vld, o_last, o_overflow, o_busy, o_word_cnt,
                         o_vld ? o_slice : 8'h00};

    cordic_result_reader dut (
        .i_clk       (i_clk),
        .i_async_rst (i_async_rst),
        .i_enable    (i_enable),
        .i_stop_code (i_stop_code),
        .i_vld       (i_vld),
        .i_data      (i_data),
        .i_rdy       (i_rdy),
        .o_vld       (o_vld),
        .o_slice     (o_slice),
        .o_last      (o_last),
        .o_word_cnt  (o_word_cnt),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_clear();
        m_fifo.delete();
        m_cur   = '0;
        m_rem   = 0;
        m_match = 1'b0;
        m_done  = 1'b0;
        m_cnt   = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic vld, input logic [55:0] data, input logic en,
                              input logic rdy, input logic [48:0] stop);
        int pre_size;
        bit pop;
        pre_size = m_fifo.size();
        pop = 1'b0;
        if (m_done) begin
            if (!en) begin
                m_fifo.delete();
                m_cnt  = '0;
                m_done = 1'b0;
            end
        end else if (m_rem == 0) begin
            pop = (pre_size > 0);
        end else if (rdy) begin
            if (m_rem == 1) begin
                m_cnt = m_cnt + 16'd1;
                if (m_match) begin
                    m_done = 1'b1;
                    m_rem  = 0;
                end else if (pre_size > 0) begin
                    pop = 1'b1;
                end else begin
                    m_rem = 0;
                end
            end else begin
                m_rem--;
            end
        end
        if (pop) begin
            m_cur   = m_fifo.pop_front();
            m_match = (m_cur[48:0] == stop);
            m_rem   = 7;
        end
        if (vld && en) begin
            if (pre_size < 4 || pop) m_fifo.push_back(data);
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [27:0] exp_out();
        logic [55:0] t;
        logic [7:0]  sl;
        logic        v, l, b;
        v  = (m_rem != 0);
        sl = 8'h00;
        if (v) begin
            t  = m_cur >> (8 * (m_rem - 1));
            sl = t[7:0];
        end
        l = v && m_match && (m_rem == 1);
        b = v || m_done || (m_fifo.size() != 0);
        return {v, l, m_ovf, b, m_cnt, sl};
    endfunction

    task automatic tick(input logic vld, input logic [55:0] data, input logic en,
                        input logic rdy);
        i_vld    = vld;
        i_data   = data;
        i_enable = en;
        i_rdy    = rdy;
        model_step(vld, data, en, rdy, i_stop_code);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_async_rst = 1'b0;
        i_vld       = 1'b0;
        i_enable    = 1'b1;
        i_rdy       = 1'b0;
        model_clear();
        @(posedge i_clk);
        #1;
        i_async_rst = 1'b1;
    endtask

    function automatic logic [55:0] rand_word();
        return 56'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        #1;
        n_cmp++;
        if (obs_w !== 28'h0 || o_slice !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state obs=%h slice=%h exp=0", obs_w, o_slice);
        end
    endtask

    task automatic test_single();
        logic [55:0] w = 56'h01_2345_6789_ABCD;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick(c == 1, w, 1'b1, 1'b1);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL single cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
            if (c == 1) begin
                n_cmp++;
                if (o_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_lat_early vld=%b exp=0", o_vld);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (o_vld !== 1'b1 || o_slice !== 8'h01) begin
                    n_fail++;
                    $display("FAIL single_lat_first vld=%b slice=%h exp=1/01", o_vld, o_slice);
                end
            end
        end
        n_cmp++;
        if (o_word_cnt !== 16'd1 || o_busy !== 1'b0 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end cnt=%0d busy=%b last=%b exp=1/0/0",
                     o_word_cnt, o_busy, o_last);
        end
    endtask

    task automatic test_rdy_toggle();
        logic [55:0] w = 56'h01_2345_6789_ABCD;
        logic [55:0] t;
        logic [7:0]  got[$];
        logic        rdy;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            rdy = (c % 2 == 1);
            if (o_vld && rdy) got.push_back(o_slice);
            tick(c == 1, w, 1'b1, rdy);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL rdy_toggle cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
        end
        n_cmp++;
        if (got.size() != 7 || o_word_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rdy_toggle_count slices=%0d cnt=%0d exp=7/1", got.size(), o_word_cnt);
        end else begin
            for (int k = 0; k < 7; k++) begin
                t = w >> (8 * (6 - k));
                n_cmp++;
                if (got[k] !== t[7:0]) begin
                    n_fail++;
                    $display("FAIL rdy_toggle_order k=%0d got=%h exp=%h", k, got[k], t[7:0]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [55:0] w[6];
        int hs = 0;
        do_reset();
        for (int k = 0; k < 6; k++) w[k] = rand_word();
        for (int c = 1; c <= 45; c++) begin
            if (o_vld) hs++;
            tick(c <= 6, w[(c <= 6) ? c - 1 : 0], 1'b1, 1'b1);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL overflow cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
            if (c == 5 || c == 6) begin
                n_cmp++;
                if (o_overflow !== (c == 6)) begin
                    n_fail++;
                    $display("FAIL overflow_flag cyc%0d ovf=%b exp=%b", c, o_overflow, c == 6);
                end
            end
        end
        n_cmp++;
        if (hs != 35 || o_word_cnt !== 16'd5 || o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_end slices=%0d cnt=%0d ovf=%b exp=35/5/1",
                     hs, o_word_cnt, o_overflow);
        end
    endtask

    task automatic test_stop();
        logic [7:0] last_slice = 8'h00;
        int         n_last = 0;
        do_reset();
        i_stop_code = 49'h1_FFFF_FFFF_FFFF;
        for (int c = 1; c <= 14; c++) begin
            tick(c <= 2, (c == 1) ? 56'hAB_FFFF_FFFF_FFFF : 56'h11_0000_0000_0000, 1'b1, 1'b1);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL stop cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
            if (o_last) begin
                n_last++;
                last_slice = o_slice;
            end
        end
        n_cmp++;
        if (n_last != 1 || last_slice !== 8'hFF || o_vld !== 1'b0 || o_busy !== 1'b1
            || o_word_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stop_done lasts=%0d slice=%h vld=%b busy=%b cnt=%0d exp=1/ff/0/1/1",
                     n_last, last_slice, o_vld, o_busy, o_word_cnt);
        end
        tick(1'b0, '0, 1'b0, 1'b1);
        n_cmp++;
        if (o_word_cnt !== 16'd0 || o_busy !== 1'b0 || obs_w !== exp_out()) begin
            n_fail++;
            $display("FAIL stop_flush cnt=%0d busy=%b exp=0/0", o_word_cnt, o_busy);
        end
        i_stop_code = 49'h0_DEAD_BEEF_0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            tick(c == 1 || c == 11, rand_word(), 1'b1, 1'b1);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL arst_pre cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
        end
        // Second word loaded at edge 12, three slices accepted by edge 15.
        #2;
        i_async_rst = 1'b0;
        #1;
        n_cmp++;
        if (o_vld !== 1'b0 || o_slice !== 8'h00 || o_word_cnt !== 16'd0 || obs_w !== 28'h0) begin
            n_fail++;
            $display("FAIL arst_immediate vld=%b slice=%h cnt=%0d exp=0/00/0",
                     o_vld, o_slice, o_word_cnt);
        end
        model_clear();
        @(posedge i_clk);
        #1;
        i_async_rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick(c == 1, 56'h0102_0304_0506_07, 1'b1, 1'b1);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL arst_post cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
            if (c == 2) begin
                n_cmp++;
                if (o_vld !== 1'b1 || o_slice !== 8'h01) begin
                    n_fail++;
                    $display("FAIL arst_first vld=%b slice=%h exp=1/01", o_vld, o_slice);
                end
            end
        end
    endtask

    task automatic test_full_pushpop();
        int hs = 0;
        do_reset();
        for (int c = 1; c <= 50; c++) begin
            if (o_vld) hs++;
            tick(c <= 5 || c == 9, rand_word(), 1'b1, 1'b1);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL pushpop cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
        end
        n_cmp++;
        if (hs != 42 || o_word_cnt !== 16'd6 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_end slices=%0d cnt=%0d ovf=%b exp=42/6/0",
                     hs, o_word_cnt, o_overflow);
        end
    endtask

    task automatic test_random();
        logic [55:0] w;
        do_reset();
        i_stop_code = 49'($urandom()) ^ {$urandom(16'hFFFF), 33'h0};
        for (int c = 1; c <= 600; c++) begin
            w = rand_word();
            if ($urandom_range(7) == 0) w[48:0] = i_stop_code;
            tick($urandom_range(2) == 0, w, $urandom_range(9) != 0, $urandom_range(3) != 0);
            n_cmp++;
            if (obs_w !== exp_out()) begin
                n_fail++;
                $display("FAIL random cyc%0d obs=%h exp=%h", c, obs_w, exp_out());
            end
        end
        i_stop_code = 49'h0_DEAD_BEEF_0000;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_rdy_toggle();
        test_overflow();
        test_stop();
        test_async_reset();
        test_full_pushpop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
